// File: rtl/multi_cycle_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/writeback per instruction.
// Latency: 3-5 cycles per instruction when mem_ready=1; FETCH/MEMREAD/MEMWRITE stretch while mem_ready=0.
// Backpressure: mem_ready low holds the FSM in its memory state; all other states last one cycle.
// Ports: clk/rst (sync active-high); op/funct3/funct7b5 from the instruction register;
//        zero/lt ALU flags; mem_ready memory handshake; write enables, datapath mux selects,
//        alu_control, imm_src and the illegal-opcode trap flag.
module multi_cycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       lt,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       adr_src,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [2:0] imm_src,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRWB, S_LUI, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t state_q, state_d;

  // Unmasked write enables; reset masks them at the output.
  logic pc_write_raw, ir_write_raw, mem_write_raw, reg_write_raw;
  logic branch_taken;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Immediate format depends only on the opcode, independent of state.
  always_comb begin
    imm_src = 3'b000;
    case (op)
      OP_STORE:  imm_src = 3'b001;
      OP_BRANCH: imm_src = 3'b010;
      OP_LUI:    imm_src = 3'b011;
      OP_JAL:    imm_src = 3'b100;
      default:   imm_src = 3'b000;
    endcase
  end

  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      3'b000:  branch_taken = zero;
      3'b001:  branch_taken = ~zero;
      3'b100:  branch_taken = lt;
      3'b101:  branch_taken = ~lt;
      default: branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    adr_src       = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_control   = ALU_ADD;
    illegal       = 1'b0;

    case (state_q)
      S_FETCH: begin
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        case (funct3)
          // funct7b5 only selects sub for register-register ops; addi ignores it.
          3'b000:  alu_control = (state_q == S_EXECR && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b100:  alu_control = ALU_XOR;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a    = 2'b10;
        alu_control  = ALU_SUB;
        pc_write_raw = branch_taken;
        state_d      = S_FETCH;
      end
      S_JAL: begin
        // PC <- OldPC + imm computed in DECODE's ALUOut; link value comes in ALUWB.
        alu_src_a    = 2'b01;
        alu_src_b    = 2'b10;
        pc_write_raw = 1'b1;
        state_d      = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a    = 2'b10;
        alu_src_b    = 2'b01;
        result_src   = 2'b10;
        pc_write_raw = 1'b1;
        state_d      = S_JALRWB;
      end
      S_JALRWB: begin
        alu_src_a     = 2'b01;
        alu_src_b     = 2'b10;
        result_src    = 2'b10;
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_LUI: begin
        result_src    = 2'b11;
        reg_write_raw = 1'b1;
        state_d       = S_FETCH;
      end
      S_TRAP: begin
        illegal = ~rst;
        state_d = S_TRAP;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign pc_write  = pc_write_raw  & ~rst;
  assign ir_write  = ir_write_raw  & ~rst;
  assign mem_write = mem_write_raw & ~rst;
  assign reg_write = reg_write_raw & ~rst;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Bench for multi_cycle_controller: per-instruction expected output sequences, directed + random.
// Latency: checks every cycle on the falling edge.
// Backpressure: mem_ready stalls randomised on FETCH/MEMREAD/MEMWRITE; ignored elsewhere.
module tb_multi_cycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, lt, mem_ready;
  logic       pc_write, ir_write, mem_write, reg_write, adr_src, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] alu_control, imm_src;

  int checks = 0;
  int passed = 0;

  multi_cycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .lt(lt), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .mem_write(mem_write), .reg_write(reg_write),
    .adr_src(adr_src), .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .imm_src(imm_src), .illegal(illegal)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTYPE = 7'b0110011,
                         ITYPE = 7'b0010011, BR = 7'b1100011, JAL = 7'b1101111,
                         JALR = 7'b1100111, LUI = 7'b0110111;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3, XOR_ = 3'd4, SLT = 3'd5;

  // {pcw, irw, mw, rw, adr, rs[1:0], a[1:0], b[1:0], alu[2:0], illegal}
  function automatic logic [14:0] mk(input logic pcw, irw, mw, rw, adr,
                                     input logic [1:0] rs, a, b, input logic [2:0] alu,
                                     input logic ill);
    return {pcw, irw, mw, rw, adr, rs, a, b, alu, ill};
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    if (o == STORE) return 3'b001;
    if (o == BR)    return 3'b010;
    if (o == LUI)   return 3'b011;
    if (o == JAL)   return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [2:0] exec_alu(input logic [2:0] f3, input logic f7, input logic is_r);
    case (f3)
      3'b000:  return (is_r && f7) ? SUB : ADD;
      3'b010:  return SLT;
      3'b100:  return XOR_;
      3'b110:  return OR_;
      3'b111:  return AND_;
      default: return ADD;
    endcase
  endfunction

  function automatic logic taken(input logic [2:0] f3, input logic z, input logic l);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return l;
      3'b101:  return !l;
      default: return 1'b0;
    endcase
  endfunction

  // Drive one cycle of inputs, check outputs mid-cycle, advance past the next rising edge.
  task automatic step(input logic r, input logic mr, input logic [14:0] e, input string tag);
    logic [17:0] obs, exp_v;
    rst = r;
    mem_ready = mr;
    @(negedge clk);
    obs   = {pc_write, ir_write, mem_write, reg_write, adr_src, result_src,
             alu_src_a, alu_src_b, alu_control, illegal, imm_src};
    exp_v = {e, imm_of(op)};
    checks++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s op=%b observed=%h expected=%h", tag, op, obs, exp_v);
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Whole instruction from FETCH until the cycle before the next FETCH.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input logic l, input int fstall, input int mstall);
    op = o; funct3 = f3; funct7b5 = f7; zero = z; lt = l;
    for (int i = 0; i < fstall; i++) step(0, 0, mk(0,0,0,0,0,2'b10,2'b00,2'b10,ADD,0), "fetch_stall");
    step(0, 1, mk(1,1,0,0,0,2'b10,2'b00,2'b10,ADD,0), "fetch");
    step(0, rnd(), mk(0,0,0,0,0,2'b00,2'b01,2'b01,ADD,0), "decode");
    if (o == LOAD) begin
      step(0, rnd(), mk(0,0,0,0,0,2'b00,2'b10,2'b01,ADD,0), "memadr");
      for (int i = 0; i < mstall; i++) step(0, 0, mk(0,0,0,0,1,2'b00,2'b00,2'b00,ADD,0), "memread_stall");
      step(0, 1, mk(0,0,0,0,1,2'b00,2'b00,2'b00,ADD,0), "memread");
      step(0, rnd(), mk(0,0,0,1,0,2'b01,2'b00,2'b00,ADD,0), "memwb");
    end else if (o == STORE) begin
      step(0, rnd(), mk(0,0,0,0,0,2'b00,2'b10,2'b01,ADD,0), "memadr");
      for (int i = 0; i < mstall; i++) step(0, 0, mk(0,0,1,0,1,2'b00,2'b00,2'b00,ADD,0), "memwrite_stall");
      step(0, 1, mk(0,0,1,0,1,2'b00,2'b00,2'b00,ADD,0), "memwrite");
    end else if (o == RTYPE || o == ITYPE) begin
      step(0, rnd(), mk(0,0,0,0,0,2'b00,2'b10,(o == ITYPE) ? 2'b01 : 2'b00,
                        exec_alu(f3, f7, o == RTYPE),0), "exec");
      step(0, rnd(), mk(0,0,0,1,0,2'b00,2'b00,2'b00,ADD,0), "aluwb");
    end else if (o == BR) begin
      step(0, rnd(), mk(taken(f3, z, l),0,0,0,0,2'b00,2'b10,2'b00,SUB,0), "branch");
    end else if (o == JAL) begin
      step(0, rnd(), mk(1,0,0,0,0,2'b00,2'b01,2'b10,ADD,0), "jal");
      step(0, rnd(), mk(0,0,0,1,0,2'b00,2'b00,2'b00,ADD,0), "jal_aluwb");
    end else if (o == JALR) begin
      step(0, rnd(), mk(1,0,0,0,0,2'b10,2'b10,2'b01,ADD,0), "jalr");
      step(0, rnd(), mk(0,0,0,1,0,2'b10,2'b01,2'b10,ADD,0), "jalrwb");
    end else if (o == LUI) begin
      step(0, rnd(), mk(0,0,0,1,0,2'b11,2'b00,2'b00,ADD,0), "lui");
    end else begin
      for (int i = 0; i < 12; i++) step(0, rnd(), mk(0,0,0,0,0,2'b00,2'b00,2'b00,ADD,1), "trap");
      step(1, rnd(), mk(0,0,0,0,0,2'b00,2'b00,2'b00,ADD,0), "trap_rst");
    end
  endtask

  logic [6:0] pool [8];
  logic [6:0] ro;

  initial begin
    pool = '{RTYPE, ITYPE, LOAD, STORE, BR, JAL, JALR, LUI};
    rst = 1'b1; mem_ready = 1'b1; op = RTYPE; funct3 = 3'b000;
    funct7b5 = 1'b0; zero = 1'b0; lt = 1'b0;
    @(posedge clk);
    #1;
    // Reset holds FETCH selects with all write enables masked even though mem_ready=1.
    step(1, 1, mk(0,0,0,0,0,2'b10,2'b00,2'b10,ADD,0), "reset_state");

    run_instr(RTYPE, 3'b000, 1'b0, 0, 0, 0, 0);   // add
    run_instr(RTYPE, 3'b000, 1'b1, 0, 0, 1, 0);   // sub
    run_instr(ITYPE, 3'b000, 1'b1, 0, 0, 0, 0);   // addi ignores funct7b5
    run_instr(RTYPE, 3'b111, 1'b0, 0, 0, 0, 0);   // and
    run_instr(ITYPE, 3'b011, 1'b0, 0, 0, 0, 0);   // unlisted funct3 -> add
    run_instr(LOAD,  3'b010, 1'b0, 0, 0, 0, 3);   // lw, 3-cycle memory stall
    run_instr(STORE, 3'b010, 1'b0, 0, 0, 2, 2);   // sw with stalls
    run_instr(BR,    3'b000, 1'b0, 1, 0, 0, 0);   // beq zero=1 taken
    run_instr(BR,    3'b001, 1'b0, 1, 0, 0, 0);   // bne zero=1 not taken
    run_instr(BR,    3'b100, 1'b0, 0, 1, 0, 0);   // blt lt=1 taken
    run_instr(BR,    3'b010, 1'b0, 1, 1, 0, 0);   // unsupported funct3 never taken
    run_instr(JAL,   3'b000, 1'b0, 0, 0, 0, 0);
    run_instr(JALR,  3'b000, 1'b0, 0, 0, 0, 0);
    run_instr(LUI,   3'b000, 1'b0, 0, 0, 0, 0);
    run_instr(7'b1111111, 3'b000, 1'b0, 0, 0, 0, 0);  // trap then reset pulse

    // Reset during a MEMWRITE stall: mem_write drops in the reset cycle, then FETCH.
    op = STORE; funct3 = 3'b010;
    step(0, 1, mk(1,1,0,0,0,2'b10,2'b00,2'b10,ADD,0), "rs_fetch");
    step(0, 1, mk(0,0,0,0,0,2'b00,2'b01,2'b01,ADD,0), "rs_decode");
    step(0, 1, mk(0,0,0,0,0,2'b00,2'b10,2'b01,ADD,0), "rs_memadr");
    step(0, 0, mk(0,0,1,0,1,2'b00,2'b00,2'b00,ADD,0), "rs_memwrite_stall");
    step(1, 0, mk(0,0,0,0,1,2'b00,2'b00,2'b00,ADD,0), "rs_memwrite_rst");
    run_instr(LUI, 3'b000, 1'b0, 0, 0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        ro = 7'($urandom);
        if (ro inside {RTYPE, ITYPE, LOAD, STORE, BR, JAL, JALR, LUI}) ro = 7'b0000000;
      end else begin
        ro = pool[$urandom_range(0, 7)];
      end
      run_instr(ro, 3'($urandom), rnd(), rnd(), rnd(),
                $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/multi_cycle_controller.md
MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 clk  in  1  rising-edge clock; all state changes on posedge clk.
REQ-002 rst  in  1  reset; one clock, synchronous, active-high.
REQ-003 op  in  7  opcode, instr[6:0] from the instruction register.
REQ-004 funct3  in  3  instr[14:12]; funct7b5  in  1  instr[30].
REQ-005 zero  in  1  ALU result==0; lt  in  1  signed rs1<rs2 from the ALU.
REQ-006 mem_ready  in  1  memory access completes this cycle.
REQ-007 pc_write, ir_write, mem_write, reg_write  out  1 each  write enables.
REQ-008 adr_src  out  1  memory address select: 0=PC, 1=ALUOut.
REQ-009 result_src  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult, 11=ImmExt.
REQ-010 alu_src_a  out  2  ALU A select: 00=PC, 01=OldPC, 10=RD1.
REQ-011 alu_src_b  out  2  ALU B select: 00=RD2, 01=ImmExt, 10=constant 4.
REQ-012 alu_control  out  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
REQ-013 imm_src  out  3  immediate-extender select: 000 I, 001 S, 010 B, 011 U, 100 J.
REQ-014 illegal  out  1  unsupported opcode trapped.

Function
REQ-015 Moore FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, JALRWB, LUI, TRAP.
REQ-016 imm_src is a combinational function of op in every state: 0000011/0010011/1100111 give 000; 0100011 gives 001; 1100011 gives 010; 0110111 gives 011; 1101111 gives 100; any other op gives 000.
REQ-017 Any output not listed for a state SHALL be 0; alu_control defaults to add.
REQ-018 FETCH: adr_src=0, a=00, b=10, add, result_src=10. ir_write=pc_write=mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
REQ-019 DECODE: a=01, b=01, add (branch target into ALUOut).
REQ-020 DECODE next state by op: load/store to MEMADR; 0110011 to EXECR; 0010011 to EXECI; 1100011 to BRANCH; 1101111 to JAL; 1100111 to JALR; 0110111 to LUI; any other to TRAP.
REQ-021 MEMADR: a=10, b=01, add. Next is MEMREAD for op 0000011, otherwise MEMWRITE.
REQ-022 MEMREAD: adr_src=1, result_src=00. Hold while mem_ready=0; go to MEMWB when mem_ready=1.
REQ-023 MEMWB: result_src=01, reg_write=1, then FETCH.
REQ-024 MEMWRITE: adr_src=1, result_src=00, mem_write=1. Hold while mem_ready=0 with mem_write held at 1; go to FETCH when mem_ready=1.
REQ-025 EXECR: a=10, b=00. EXECI: a=10, b=01. Both go to ALUWB.
REQ-026 EXECR/EXECI alu_control by funct3: 000 gives sub only when EXECR and funct7b5=1, otherwise add; 010 slt; 100 xor; 110 or; 111 and; any other funct3 gives add.
REQ-027 ALUWB: result_src=00, reg_write=1, then FETCH.
REQ-028 BRANCH: a=10, b=00, sub, result_src=00. pc_write = (funct3 000: zero; 001: !zero; 100: lt; 101: !lt; any other funct3: 0). Then FETCH.
REQ-029 JAL: a=01, b=10, add, result_src=00 (OldPC+imm), pc_write=1, then ALUWB.
REQ-030 JALR: a=10, b=01, add, result_src=10, pc_write=1, then JALRWB.
REQ-031 JALRWB: a=01, b=10, add, result_src=10, reg_write=1, then FETCH.
REQ-032 LUI: result_src=11, reg_write=1, then FETCH.
REQ-033 TRAP: illegal=1 and all write enables 0. TRAP is absorbing; only rst exits it.
REQ-034 Only FETCH, MEMREAD and MEMWRITE sample mem_ready; every other state lasts exactly one cycle.
REQ-035 Cycle counts with mem_ready=1: R/I = 4; load = 5; store = 4; branch = 3; jal = 4; jalr = 4; lui = 3.

Reset
REQ-036 rst=1 at a posedge SHALL load state FETCH from any state, including TRAP and a mid-instruction stall.
REQ-037 While rst=1, pc_write, ir_write, mem_write and reg_write SHALL be forced to 0 and illegal SHALL be 0.
REQ-038 In the first cycle after rst falls, outputs SHALL be the FETCH values.

Verification
REQ-039 add (op 0110011, funct3 000, funct7b5 0), mem_ready=1 -> FETCH, DECODE, EXECR (alu_control 000), ALUWB (reg_write=1, result_src 00), back to FETCH.
REQ-040 lw with mem_ready low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles with reg_write=0; MEMWB asserts reg_write=1, result_src 01; total 8 cycles.
REQ-041 beq/bne (funct3 000/001) with zero=1 -> BRANCH pc_write 1 for beq and 0 for bne; blt with lt=1 gives pc_write 1.
REQ-042 jalr -> JALR (pc_write=1, result_src 10, a=10, b=01), then JALRWB (reg_write=1, a=01, b=10), imm_src 000 throughout.
REQ-043 op 1111111 -> TRAP, illegal=1 for 10+ cycles with no write enables; rst pulse returns to FETCH with illegal=0.
REQ-044 rst asserted during a MEMWRITE stall -> mem_write drops to 0 in the rst cycle; next state FETCH.
